// File: rtl/pc_rx_pkg.sv
// rtl/pc_rx_pkg.sv - shared types, channel indices and width helper for the PC receive path
package pc_rx_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int CH_INS = 0;
    localparam int CH_CFG = 1;

    // Index width for a given count; never below 1 so single-bit selects stay legal.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pc_rx_rr_penc.sv
// rtl/pc_rx_rr_penc.sv - rotate-priority encoder: first requester searching from last+1
module pc_rx_rr_penc
    import pc_rx_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int IW     = clog2(CH_NUM)
)
(
    input  logic [CH_NUM-1:0] i_req,
    input  logic [IW-1:0]     i_last,
    output logic [IW-1:0]     o_idx,
    output logic              o_any
);

    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 1; k <= CH_NUM; k++) begin
            if (!o_any && i_req[(int'(i_last) + k) % CH_NUM]) begin
                o_any = 1'b1;
                o_idx = IW'((int'(i_last) + k) % CH_NUM);
            end
        end
    end

endmodule

// File: rtl/pc_rx_rr_arbit.sv
// rtl/pc_rx_rr_arbit.sv - round-robin read arbiter for the shared frame-data BRAM
// Optional grant watchdog with forced release: PC_RX_ARBIT_TMO_EN
module pc_rx_rr_arbit
    import pc_rx_pkg::*;
#(
    parameter int U_DLY   = 1,
    parameter int CH_NUM  = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int RD_LAT  = 1,
    parameter int TMO_CYC = 4096
)
(
    input  logic                     i_clk_sys,
    input  logic                     i_rst,
    input  logic [CH_NUM-1:0]        i_rd_req,
    output logic [CH_NUM-1:0]        o_rd_ack,
    input  logic [CH_NUM-1:0]        i_rd_done,
    input  logic [CH_NUM*ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0]        o_rd_data,
    output logic [CH_NUM-1:0]        o_rd_data_valid,
    output logic [ADDR_W-1:0]        o_mux_ram_rd_addr,
    input  logic [DATA_W-1:0]        i_mux_ram_rd_data,
    output logic [clog2(CH_NUM)-1:0] o_grant_id,
    output logic                     o_busy,
    output logic                     o_tmo_err
);

    localparam int IW = clog2(CH_NUM);

    if (CH_NUM < 2 || CH_NUM > 16 || RD_LAT < 1 || RD_LAT > 4 || TMO_CYC < 2 || U_DLY < 0) begin : g_param_chk
        $error("pc_rx_rr_arbit: parameter out of range");
    end

    arb_state_t        r_state;
    logic [CH_NUM-1:0] r_ack;
    logic [IW-1:0]     r_grant;
    logic [IW-1:0]     r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [CH_NUM-1:0] r_vpipe [RD_LAT+1];
    logic [IW-1:0]     w_idx;
    logic              w_any;
    logic [ADDR_W-1:0] w_sel_addr;

`ifdef PC_RX_ARBIT_TMO_EN
    localparam int TW = clog2(TMO_CYC) + 1;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;
`endif

    pc_rx_rr_penc #(.CH_NUM(CH_NUM), .IW(IW)) u_penc (
        .i_req  (i_rd_req),
        .i_last (r_last),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );

    assign w_sel_addr = i_rd_addr[r_grant*ADDR_W +: ADDR_W];

    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_ack   <= '0;
            r_grant <= '0;
            r_last  <= IW'(CH_NUM - 1);
            r_addr  <= '0;
`ifdef PC_RX_ARBIT_TMO_EN
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
`ifdef PC_RX_ARBIT_TMO_EN
            r_tmo_err <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_idx;
                        r_last  <= w_idx;
                        r_ack   <= CH_NUM'(1) << w_idx;
                        r_state <= GRANT;
`ifdef PC_RX_ARBIT_TMO_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                GRANT: begin
                    r_addr <= w_sel_addr;
                    if (i_rd_done[r_grant]) begin
                        r_ack   <= '0;
                        r_state <= RELEASE;
                    end
`ifdef PC_RX_ARBIT_TMO_EN
                    // r_last already points at the stuck owner, so the next search skips it.
                    else if (r_tmo_cnt == TW'(TMO_CYC - 1)) begin
                        r_ack     <= '0;
                        r_tmo_err <= 1'b1;
                        r_state   <= RELEASE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // r_ack is non-zero only in GRANT, so it doubles as the tag for the address just registered.
    always_ff @(posedge i_clk_sys) begin
        if (i_rst) begin
            for (int i = 0; i <= RD_LAT; i++) r_vpipe[i] <= '0;
        end else begin
            r_vpipe[0] <= r_ack;
            for (int i = 1; i <= RD_LAT; i++) r_vpipe[i] <= r_vpipe[i-1];
        end
    end

    assign o_rd_ack          = r_ack;
    assign o_rd_data         = i_mux_ram_rd_data;
    assign o_rd_data_valid   = r_vpipe[RD_LAT];
    assign o_mux_ram_rd_addr = r_addr;
    assign o_grant_id        = r_grant;
    assign o_busy            = (r_state != IDLE);
`ifdef PC_RX_ARBIT_TMO_EN
    assign o_tmo_err         = r_tmo_err;
`else
    assign o_tmo_err         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_rx_rr_arbit.sv
// tb/tb_pc_rx_rr_arbit.sv - directed bench: RD_LAT=1 and RD_LAT=3 arbiters on shared stimulus
module tb_pc_rx_rr_arbit;
    import pc_rx_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, done;
    logic [47:0] addr;
    logic [3:0]  ack1, ack3, val1, val3;
    logic [7:0]  data1, data3, q1, q3a, q3b, q3c;
    logic [11:0] maddr1, maddr3;
    logic [1:0]  gid1, gid3;
    logic        busy1, busy3, tmo1, tmo3;
    int          n_assert = 0;
    int          n_fail = 0;
    bit          chk_en = 1'b0;
    int          order [5] = '{0, 1, 2, 3, 0};

    always #5 clk = ~clk;

    pc_rx_rr_arbit #(.CH_NUM(4), .ADDR_W(12), .DATA_W(8), .RD_LAT(1), .TMO_CYC(16)) dut (
        .i_clk_sys(clk), .i_rst(rst), .i_rd_req(req), .o_rd_ack(ack1), .i_rd_done(done),
        .i_rd_addr(addr), .o_rd_data(data1), .o_rd_data_valid(val1), .o_mux_ram_rd_addr(maddr1),
        .i_mux_ram_rd_data(q1), .o_grant_id(gid1), .o_busy(busy1), .o_tmo_err(tmo1)
    );

    pc_rx_rr_arbit #(.CH_NUM(4), .ADDR_W(12), .DATA_W(8), .RD_LAT(3), .TMO_CYC(16)) dut3 (
        .i_clk_sys(clk), .i_rst(rst), .i_rd_req(req), .o_rd_ack(ack3), .i_rd_done(done),
        .i_rd_addr(addr), .o_rd_data(data3), .o_rd_data_valid(val3), .o_mux_ram_rd_addr(maddr3),
        .i_mux_ram_rd_data(q3c), .o_grant_id(gid3), .o_busy(busy3), .o_tmo_err(tmo3)
    );

    function automatic logic [7:0] ram_f(input logic [11:0] a);
        return a[7:0] ^ {a[11:8], a[11:8]} ^ 8'h5A;
    endfunction

    always @(posedge clk) begin
        q1  <= ram_f(maddr1);
        q3a <= ram_f(maddr3);
        q3b <= q3a;
        q3c <= q3b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            n_assert++;
            assert ($onehot0(ack1) && $onehot0(ack3) && $onehot0(val1) && $onehot0(val3)) else begin
                n_fail++;
                $error("FAIL onehot0: ack1=%b ack3=%b val1=%b val3=%b expected at most one bit each", ack1, ack3, val1, val3);
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; done = '0; addr = '0;
        step; step;
        chk_en = 1'b1;
        chk("rst_ack", ack1, 0);   chk("rst_val", val1, 0);   chk("rst_maddr", maddr1, 0);
        chk("rst_gid", gid1, 0);   chk("rst_busy", busy1, 0); chk("rst_tmo", tmo1, 0);
        rst = 1'b0;

        // single requester on the instruct channel
        addr[CH_INS*12 +: 12] = 12'h123;
        req = 4'b0001;
        step;
        chk("single_ack", ack1, 4'b0001); chk("single_busy", busy1, 1); chk("single_gid", gid1, CH_INS);
        step;
        chk("single_maddr", maddr1, 12'h123); chk("single_val_early", val1, 0);
        step;
        chk("single_val", val1, 4'b0001); chk("single_data", data1, 8'h68); chk("single_val3_early", val3, 0);
        req = 4'b0000; done = 4'b0001;
        step;
        done = '0;
        chk("single_rel_ack", ack1, 0); chk("single_rel_busy", busy1, 1);
        step;
        chk("single_idle_busy", busy1, 0); chk("single_gid_hold", gid1, 0); chk("single_maddr_hold", maddr1, 12'h123);

        // all four requesting continuously from a fresh reset
        rst = 1'b1; step; rst = 1'b0;
        req = 4'b1111;
        step;
        for (int i = 0; i < 5; i++) begin
            chk("rr_ack", ack1, 1 << order[i]);
            chk("rr_gid", gid1, order[i]);
            step; step;
            done = 4'b0001 << order[i];
            step;
            done = '0;
            chk("rr_rel1", ack1, 0);
            step;
            chk("rr_rel2", ack1, 0);
            step;
        end
        chk("rr_wrap_ack", ack1, 4'b0010);
        req = '0; done = 4'b0010;
        step; done = '0; step; step;
        chk("rr_end_busy", busy1, 0);

        // foreign done on the cfg owner, then release with same-cycle re-request
        req = 4'b0010;
        step;
        chk("fd_ack", ack1, 4'b0010); chk("fd_gid", gid1, CH_CFG);
        req = 4'b1010; done = 4'b0100;
        step;
        done = '0;
        chk("fd_foreign_ack", ack1, 4'b0010); chk("fd_foreign_gid", gid1, 1);
        step;
        chk("fd_foreign_ack2", ack1, 4'b0010);
        done = 4'b0010;
        step;
        done = '0;
        chk("fd_rel_ack", ack1, 0);
        step;
        chk("fd_idle_ack", ack1, 0);
        step;
        chk("fd_next_ack", ack1, 4'b1000); chk("fd_next_gid", gid1, 3);
        req = '0; done = 4'b1000;
        step; done = '0; step; step;
        done = 4'b0001;
        step;
        done = '0;
        chk("idle_done_busy", busy1, 0); chk("idle_done_ack", ack1, 0);

        // trailing data: done on the same cycle as the last address
        req = 4'b0001;
        step;
        chk("tr_ack", ack1, 4'b0001);
        addr[0 +: 12] = 12'h0AB; addr[24 +: 12] = 12'h2C4;
        done = 4'b0001; req = 4'b0100;
        step;
        done = '0;
        chk("tr_e1_ack", ack1, 0); chk("tr_e1_maddr3", maddr3, 12'h0AB); chk("tr_e1_val3", val3, 0);
        step;
        chk("tr_e2_val1", val1, 4'b0001); chk("tr_e2_data1", data1, 8'hF1); chk("tr_e2_val3", val3, 0);
        step;
        chk("tr_e3_ack", ack3, 4'b0100); chk("tr_e3_gid", gid3, 2); chk("tr_e3_val3", val3, 0);
        step;
        chk("tr_e4_val3", val3, 4'b0001); chk("tr_e4_data3", data3, 8'hF1); chk("tr_e4_maddr1", maddr1, 12'h2C4);
        step;
        chk("tr_e5_val3", val3, 0); chk("tr_e5_val1", val1, 4'b0100); chk("tr_e5_data1", data1, 8'hBC);
        step;
        chk("tr_e6_val3", val3, 0);
        step;
        chk("tr_e7_val3", val3, 4'b0100); chk("tr_e7_data3", data3, 8'hBC);
        req = '0; done = 4'b0100;
        step; done = '0; step; step;

        // reset while channel 2 owns the RAM
        req = 4'b0100;
        step;
        chk("rm_ack", ack1, 4'b0100);
        step; step;
        rst = 1'b1;
        step;
        chk("rm_ack1", ack1, 0); chk("rm_ack3", ack3, 0); chk("rm_val1", val1, 0); chk("rm_val3", val3, 0);
        chk("rm_maddr", maddr1, 0); chk("rm_gid", gid1, 0); chk("rm_busy", busy1, 0); chk("rm_tmo", tmo1, 0);
        rst = 1'b0; req = 4'b1001;
        step;
        chk("rm_after_ack", ack1, 4'b0001); chk("rm_after_gid", gid1, 0);
        req = '0; done = 4'b0001;
        step; done = '0; step; step;

`ifdef PC_RX_ARBIT_TMO_EN
        req = 4'b1010;
        step;
        chk("tmo_ack", ack1, 4'b0010);
        for (int k = 1; k < 16; k++) begin
            step;
            chk("tmo_quiet", tmo1, 0);
            chk("tmo_hold", ack1, 4'b0010);
        end
        step;
        chk("tmo_pulse", tmo1, 1); chk("tmo_drop", ack1, 0);
        step;
        chk("tmo_one_cycle", tmo1, 0);
        step;
        chk("tmo_next_ack", ack1, 4'b1000);
        req = '0; done = 4'b1000;
        step; done = '0; step; step;
`else
        req = 4'b0010;
        step;
        chk("hold_ack", ack1, 4'b0010);
        req = '0;
        for (int k = 0; k < 1000; k++) begin
            step;
            chk("hold_tmo", tmo1, 0);
            chk("hold_ack_long", ack1, 4'b0010);
        end
        done = 4'b0010;
        step; done = '0; step;
        chk("hold_end_busy", busy1, 0);
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
